// File: rtl/mul_pkg.sv
// Shared types and helpers for the sequential multiplier controller.
package mul_pkg;

  localparam int unsigned XLEN = 32;
  // Wide enough for LAT_CYCLES-1 with LAT_CYCLES up to 15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } mul_state_e;

  // Magnitude of an operand under its signedness; 0x80000000 maps to itself.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_sign_fix.sv
// Applies two's-complement sign correction to the unsigned product and selects a word.
module mul_sign_fix
  import mul_pkg::*;
(
  input  logic [63:0]     z_i,
  input  logic            neg_i,
  input  logic            hi_i,
  output logic [XLEN-1:0] data_o
);

  logic [63:0] w_prod;

  // Negate modulo 2^64 when the operand signs differ, then pick the half.
  always_comb begin
    w_prod = neg_i ? (~z_i + 64'd1) : z_i;
    data_o = hi_i ? w_prod[63:32] : w_prod[31:0];
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencer sharing an external 32x32 multiplier for MUL/MULH/MULHSU/MULHU.
module mul_seq_ctrl #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned LAT_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [1:0]      req_op_i,
  input  logic [XLEN-1:0] req_rs1_i,
  input  logic [XLEN-1:0] req_rs2_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [XLEN-1:0] rsp_data_o,
  output logic            busy_o,
  output logic [XLEN-1:0] mul_x_o,
  output logic [XLEN-1:0] mul_y_o,
  input  logic [64:0]     mul_z_i
);

  import mul_pkg::*;

  mul_state_e         r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [XLEN-1:0]    r_x, w_x_next;
  logic [XLEN-1:0]    r_y, w_y_next;
  logic               r_neg, w_neg_next;
  logic               r_hi, w_hi_next;
  logic               r_rsp_valid, w_rsp_valid_next;
  logic [XLEN-1:0]    r_rsp_data, w_rsp_data_next;

  mul_op_e            w_op;
  logic               w_a_signed;
  logic               w_b_signed;
  logic [XLEN-1:0]    w_fix_data;
  // Product bit 64 is never meaningful for a 32x32 multiply.
  logic               w_unused_z64;

  assign w_unused_z64 = mul_z_i[64];
  assign w_op         = mul_op_e'(req_op_i);
  assign w_a_signed   = (w_op == MULH) || (w_op == MULHSU);
  assign w_b_signed   = (w_op == MULH);

  mul_sign_fix u_sign_fix (
    .z_i    (mul_z_i[63:0]),
    .neg_i  (r_neg),
    .hi_i   (r_hi),
    .data_o (w_fix_data)
  );

  // Next-state and datapath updates for the IDLE -> COMPUTE -> DONE sequence.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_x_next         = r_x;
    w_y_next         = r_y;
    w_neg_next       = r_neg;
    w_hi_next        = r_hi;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_data_next  = r_rsp_data;
    case (r_state)
      IDLE: begin
        if (req_valid_i) begin
          w_x_next     = mag(req_rs1_i, w_a_signed);
          w_y_next     = mag(req_rs2_i, w_b_signed);
          w_neg_next   = (w_a_signed & req_rs1_i[XLEN-1]) ^ (w_b_signed & req_rs2_i[XLEN-1]);
          w_hi_next    = (w_op != MUL);
          w_cnt_next   = CNT_W'(LAT_CYCLES - 1);
          w_state_next = COMPUTE;
        end
      end
      COMPUTE: begin
        if (r_cnt == '0) begin
          w_rsp_data_next  = w_fix_data;
          w_rsp_valid_next = 1'b1;
          w_state_next     = DONE;
        end else begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          w_rsp_valid_next = 1'b0;
          w_state_next     = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_neg       <= 1'b0;
      r_hi        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_x         <= w_x_next;
      r_y         <= w_y_next;
      r_neg       <= w_neg_next;
      r_hi        <= w_hi_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_data  <= w_rsp_data_next;
    end
  end

  assign req_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state == COMPUTE) || (r_state == DONE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_data_o  = r_rsp_data;
  assign mul_x_o     = r_x;
  assign mul_y_o     = r_y;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl with an external multiplier model.
module tb_mul_seq_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        busy;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [64:0] mul_z;
  logic        junk = 1'b0;

  logic [63:0] sf_z = '0;
  logic        sf_neg = 1'b0;
  logic        sf_hi = 1'b0;
  logic [31:0] sf_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  // Bit 64 carries garbage to show it is ignored.
  always @(posedge clk) junk <= ~junk;
  assign mul_z = {junk, {32'd0, mul_x} * {32'd0, mul_y}};

  mul_seq_ctrl #(.XLEN(32), .LAT_CYCLES(LAT)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op_i    (req_op),
    .req_rs1_i   (req_rs1),
    .req_rs2_i   (req_rs2),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy),
    .mul_x_o     (mul_x),
    .mul_y_o     (mul_y),
    .mul_z_i     (mul_z)
  );

  mul_sign_fix u_fix (
    .z_i    (sf_z),
    .neg_i  (sf_neg),
    .hi_i   (sf_hi),
    .data_o (sf_data)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[8];

  // Reference: extend each operand by its RV32M signedness, multiply, pick the word.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (op == 2'b01 || op == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction; hold = cycles of response backpressure.
  task automatic run_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, output logic [31:0] data, output logic [31:0] x,
                         output logic [31:0] y, output int lat);
    @(negedge clk);
    chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_rs1   = $urandom;
    req_rs2   = $urandom;
    x   = mul_x;
    y   = mul_y;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      #1;
      if (rsp_valid) break;
    end
    chk("x_held", {32'd0, mul_x}, {32'd0, x});
    chk("y_held", {32'd0, mul_y}, {32'd0, y});
    chk("busy_done", {63'd0, busy}, 64'd1);
    data = rsp_data;
    repeat (hold) @(posedge clk);
    #1;
    chk("rsp_stable", {32'd0, rsp_data}, {32'd0, data});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("rsp_cleared", {63'd0, rsp_valid}, 64'd0);
    chk("ready_after", {63'd0, req_ready}, 64'd1);
  endtask

  initial begin
    logic [31:0] d, x, y, a, b, held;
    logic [1:0]  op;
    int          lat, issued, got, cyc, seen;
    logic [31:0] expq[$];
    int          rcyc[$];
    logic [63:0] p;

    vecs[0] = '{2'b00, 32'h00000007, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB};
    vecs[1] = '{2'b01, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2] = '{2'b01, 32'hFFFFFFFF, 32'h00000005, 32'h00000001, 32'h00000005, 32'hFFFFFFFF};
    vecs[3] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[5] = '{2'b01, 32'h80000000, 32'h00000001, 32'h80000000, 32'h00000001, 32'hFFFFFFFF};
    vecs[6] = '{2'b01, 32'h00000000, 32'hFFFFFFFB, 32'h00000000, 32'h00000005, 32'h00000000};
    vecs[7] = '{2'b10, 32'h80000000, 32'h00000002, 32'h80000000, 32'h00000002, 32'hFFFFFFFF};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_mul_x", {32'd0, mul_x}, 64'd0);
    chk("rst_mul_y", {32'd0, mul_y}, 64'd0);

    // Standalone sign correction unit.
    for (int i = 0; i < 8; i++) begin
      sf_z   = (i == 0) ? 64'd0 : {$urandom, $urandom};
      sf_neg = (i == 0) ? 1'b1 : 1'($urandom);
      sf_hi  = 1'($urandom);
      #1;
      p = sf_neg ? (64'd0 - sf_z) : sf_z;
      chk("sign_fix", {32'd0, sf_data}, {32'd0, sf_hi ? p[63:32] : p[31:0]});
    end

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].op, vecs[i].a, vecs[i].b, 0, d, x, y, lat);
      chk("vec_x", {32'd0, x}, {32'd0, vecs[i].x});
      chk("vec_y", {32'd0, y}, {32'd0, vecs[i].y});
      chk("vec_lat", 64'(lat), 64'(LAT));
      chk("vec_data", {32'd0, d}, {32'd0, vecs[i].res});
    end

    // Randomized transactions with random backpressure.
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
      if (i % 5 == 0) a = 32'h80000000;
      run_txn(op, a, b, int'($urandom_range(0, 3)), d, x, y, lat);
      chk("rand_lat", 64'(lat), 64'(LAT));
      chk("rand_data", {32'd0, d}, {32'd0, model(op, a, b)});
    end

    // Backpressure in DONE with a competing request.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b10; req_rs1 = 32'hFFFFFFF0; req_rs2 = 32'h00000003;
    @(posedge clk);
    #1;
    req_rs1 = 32'h11111111; req_rs2 = 32'h22222222; req_op = 2'b11;
    held = mul_x;
    repeat (LAT) @(posedge clk);
    #1;
    chk("bp_valid0", {63'd0, rsp_valid}, 64'd1);
    d = rsp_data;
    chk("bp_data0", {32'd0, d}, {32'd0, model(2'b10, 32'hFFFFFFF0, 32'h00000003)});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("bp_data", {32'd0, rsp_data}, {32'd0, d});
      chk("bp_ready", {63'd0, req_ready}, 64'd0);
    end
    chk("bp_ignored", {32'd0, mul_x}, {32'd0, held});
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp_rel_valid", {63'd0, rsp_valid}, 64'd0);
    chk("bp_rel_ready", {63'd0, req_ready}, 64'd1);

    // Reset one cycle after accept.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b11; req_rs1 = 32'h00001234; req_rs2 = 32'h00005678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("mrst_x", {32'd0, mul_x}, 64'd0);
    chk("mrst_ready", {63'd0, req_ready}, 64'd1);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1;
    end
    chk("mrst_no_rsp", 64'(seen), 64'd0);

    // Back-to-back with req_valid held high.
    rsp_ready = 1'b1;
    issued = 0; got = 0; cyc = 0;
    while (got < 3 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        if (expq.size() == 0) chk("b2b_spurious", 64'd1, 64'd0);
        else chk("b2b_data", {32'd0, rsp_data}, {32'd0, expq.pop_front()});
        rcyc.push_back(cyc);
        got++;
      end
      if (req_ready && issued < 3) begin
        op = 2'($urandom); a = $urandom; b = $urandom;
        req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
        expq.push_back(model(op, a, b));
        issued++;
      end else if (issued >= 3) begin
        req_valid = 1'b0;
      end
    end
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("b2b_count", 64'(got), 64'd3);
    if (rcyc.size() == 3) begin
      chk("b2b_gap1", 64'(rcyc[1] - rcyc[0]), 64'(LAT + 2));
      chk("b2b_gap2", 64'(rcyc[2] - rcyc[1]), 64'(LAT + 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
Multi-cycle sequencer that shares one combinational 32x32 unsigned array multiplier (65-bit product port) with the RV32M execute stage.
- Accepts one MUL/MULH/MULHSU/MULHU request through a valid/ready handshake.
- Drives magnitude operands to the multiplier and holds them stable for LAT_CYCLES cycles, because the multiplier is a multicycle timing path.
- Applies two's-complement sign correction, selects the low or high word, and returns the result through a valid/ready response handshake.

Parameters:
XLEN, 32, operand width; only 32 is supported.
LAT_CYCLES, 2, cycles mul_x_o/mul_y_o are held before the product is sampled; legal range 1..15.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  synchronous, active-high reset.
req_valid_i  in  1  request present.
req_ready_o  out  1  controller can accept a request (high only in IDLE).
req_op_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
req_rs1_i  in  32  operand A.
req_rs2_i  in  32  operand B.
rsp_valid_o  out  1  result valid.
rsp_ready_i  in  1  consumer takes the result.
rsp_data_o  out  32  result word.
busy_o  out  1  high in COMPUTE or DONE.
mul_x_o  out  32  multiplier operand X (registered).
mul_y_o  out  32  multiplier operand Y (registered).
mul_z_i  in  65  multiplier product; only bits [63:0] are used, bit 64 is ignored.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values (after a clock edge with rst_i high):
  - state = IDLE.
  - rsp_valid_o = 0, rsp_data_o = 0, busy_o = 0.
  - mul_x_o = 0, mul_y_o = 0, cycle counter = 0, neg flag = 0, hi flag = 0.
  - req_ready_o = 1 in the cycle following reset.
- Reset mid-operation: rst_i overrides everything in any state. An in-flight request is dropped and no response is produced.
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i & req_ready_o, the request is accepted and the following are registered:
    - Signedness. A is signed for MULH and MULHSU. B is signed only for MULH.
    - Magnitudes: |A| if signed and A[31]=1, else A; same rule for |B|. These go to mul_x_o/mul_y_o. 0x80000000 stays 0x80000000 (magnitude 2^31, unsigned).
    - neg = (A signed & A[31]) XOR (B signed & B[31]).
    - hi = (op != 00).
  - Counter loads LAT_CYCLES-1; next state COMPUTE.
- COMPUTE:
  - mul_x_o/mul_y_o are held constant.
  - If counter = 0: compute P = neg ? (~mul_z_i[63:0] + 1) mod 2^64 : mul_z_i[63:0]. Register rsp_data_o = hi ? P[63:32] : P[31:0], set rsp_valid_o, go to DONE.
  - Otherwise decrement the counter.
- DONE:
  - rsp_valid_o = 1; rsp_data_o is stable until the handshake.
  - On rsp_ready_i: rsp_valid_o is cleared next cycle and next state is IDLE.
  - No request is accepted in the same cycle; minimum issue interval is LAT_CYCLES+2 cycles.
- Latency: with the request accepted at edge E0, rsp_valid_o is high after edge E(LAT_CYCLES).
- Signals outside IDLE:
  - req_ready_o = 0 outside IDLE.
  - req_* inputs are ignored outside IDLE.
  - rsp_ready_i is ignored outside DONE.
- Width rules:
  - Negation is 64-bit modulo 2^64.
  - MUL results are identical for all sign interpretations, so MUL always uses neg = 0.
  - A zero product with neg = 1 yields 0.
- No X propagation: rsp_data_o holds its last value when not in DONE (0 after reset).

Decomposition:
- Package mul_pkg:
  - typedef mul_op_e {MUL=2'b00, MULH=2'b01, MULHSU=2'b10, MULHU=2'b11}.
  - typedef mul_state_e {IDLE, COMPUTE, DONE}.
  - localparam XLEN = 32.
- One natural combinational sub-module, mul_sign_fix: inputs z[63:0], neg, hi; output the 32-bit result word. It is instantiated in COMPUTE capture and unit-tested standalone.
- The multiplier itself stays outside the block and connects through mul_x_o/mul_y_o/mul_z_i.

Test Plan:
1. MUL, rs1=7, rs2=0xFFFFFFFD, LAT_CYCLES=2 -> mul_x_o=7, mul_y_o=0xFFFFFFFD; rsp_valid_o after 2 edges post-accept; rsp_data_o=0xFFFFFFEB.
2. MULH, rs1=0x80000000, rs2=0x80000000 -> mul_x_o=mul_y_o=0x80000000, neg=0, rsp_data_o=0x40000000; also MULH rs1=0xFFFFFFFF, rs2=5 -> 0xFFFFFFFF.
3. MULHSU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF -> mul_x_o=1, mul_y_o=0xFFFFFFFF, neg=1, rsp_data_o=0xFFFFFFFF. MULHU with the same operands -> 0xFFFFFFFE.
4. Backpressure: hold rsp_ready_i=0 for 5 cycles in DONE -> rsp_valid_o=1 and rsp_data_o unchanged, req_ready_o=0, a new req_valid_i is ignored. Release -> IDLE next cycle, req_ready_o=1.
5. Reset mid-COMPUTE: assert rst_i one cycle after accept -> next cycle state IDLE, rsp_valid_o=0, mul_x_o=0, req_ready_o=1; no response ever appears.
6. Back-to-back: issue 3 requests with req_valid_i held high and rsp_ready_i=1 -> exactly 3 responses in order, spaced LAT_CYCLES+2 cycles apart, each matching a reference model.
